job_sequencer: RTL and testbench
================================

JOB_SEQUENCER -- requirements
Module: job_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: req  in  1  host job request; accepted only when req=1 and rdy=1 at a clk edge.
REQ-004 SHALL have: abort  in  1  host abort of active job.
REQ-005 SHALL have: eng_done  in  1  engine reports job complete.
REQ-006 SHALL have: eng_err  in  1  engine reports job failure.
REQ-007 SHALL have: timeout_cfg  in  8  watchdog limit in RUN cycles; 0 = watchdog disabled.
REQ-008 SHALL have outputs, all 1 bit: rdy (idle, can accept), start (launch pulse), enable (engine run enable), endd (done pulse), stop (abort pulse), er (error pulse), rt (retry pulse), interrupt (completion pulse), ack (acceptance ack).
REQ-009 SHALL have: retry_cnt  out  2  retries used by current job.

Function
REQ-010 SHALL implement FSM states IDLE, LAUNCH, RUN, DONE, STOP, ERR, RETRY; all outputs decoded from registered state/counters (no input-to-output combinational path).
REQ-011 IDLE: rdy=1; acceptance -> LAUNCH, retry_cnt cleared to 0; abort, eng_done, eng_err ignored.
REQ-012 LAUNCH: start=1 for exactly one cycle; watchdog counter cleared; -> RUN unless abort.
REQ-013 RUN: enable=1; watchdog increments each RUN cycle.
REQ-014 RUN exit priority, highest first: abort -> STOP; eng_err -> ERR; eng_done -> DONE; watchdog reaching timeout_cfg (timeout_cfg != 0) -> ERR; else stay.
REQ-015 Watchdog fires after exactly timeout_cfg consecutive RUN cycles without another exit; 8-bit counter never wraps.
REQ-016 DONE: endd=1 and interrupt=1 for one cycle -> IDLE.
REQ-017 STOP: stop=1 and interrupt=1 for one cycle -> IDLE.
REQ-018 ERR: er=1 for one cycle; abort -> STOP; else retry_cnt<3 -> RETRY; else (retry_cnt=3) interrupt=1 same cycle -> IDLE.
REQ-019 RETRY: rt=1 for one cycle, enable=0, retry_cnt incremented on entry; abort -> STOP; else -> LAUNCH.
REQ-020 enable SHALL be 1 only in RUN; rt and enable never both 1.
REQ-021 abort in LAUNCH, RUN, RETRY or ERR -> STOP on next cycle.
REQ-022 rdy SHALL be 0 in every state except IDLE; rdy returns to 1 the cycle after DONE, STOP or final ERR.
REQ-023 ack: acceptance at edge T SHALL give ack=1 for exactly the cycle T+5 (5-stage shift register); independent of later FSM events (abort, error) except reset.
REQ-024 Ack pipe SHALL handle overlapping acceptances (a second job accepted before the first ack emerges), one ack pulse per acceptance.
REQ-025 retry_cnt SHALL hold its value in IDLE until next acceptance; saturates at 3.
REQ-026 Cycle timing for acceptance at edge T: start=1 cycle T+1, enable=1 from T+2.

Reset
REQ-027 rst=0 SHALL immediately (asynchronously) force IDLE: rdy=1; start, enable, endd, stop, er, rt, interrupt, ack=0; retry_cnt=0; watchdog=0; ack pipe cleared.
REQ-028 Reset mid-job SHALL discard the job and any pending ack; no interrupt generated.
REQ-029 First acceptance possible at the first clk edge with rst=1.

Verification
REQ-030 Normal job: timeout_cfg=0, req at T -> start T+1, enable T+2.., ack T+5; eng_done at T+7 -> endd=1, interrupt=1 in T+8, rdy=1 in T+9, retry_cnt=0.
REQ-031 Watchdog: timeout_cfg=4, no engine response, req at T -> RUN T+2..T+5, er=1 T+6, rt=1 T+7 with retry_cnt=1, start=1 T+8.
REQ-032 Retry exhaustion: eng_err held 1 -> three rt pulses (retry_cnt 1,2,3), fourth er with interrupt=1, then rdy=1; retry_cnt reads 3 until next req.
REQ-033 Simultaneous events: abort, eng_err, eng_done all 1 in one RUN cycle -> next cycle stop=1, interrupt=1, er=0, endd=0.
REQ-034 Reset mid-RUN: rst=0 at T+3 after acceptance at T -> outputs at reset values immediately, no ack at T+5, rdy=1.
REQ-035 Ignored request: req=1 while rdy=0 (job running) -> no ack, no second start; req in IDLE after completion accepted normally.

Source files
------------

// File: rtl/job_sequencer.sv
// Job sequencer: accepts host jobs, launches and supervises an engine
// run with watchdog, bounded retries, abort handling and a fixed-latency ack.
module job_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       abort,
    input  logic       eng_done,
    input  logic       eng_err,
    input  logic [7:0] timeout_cfg,
    output logic       rdy,
    output logic       start,
    output logic       enable,
    output logic       endd,
    output logic       stop,
    output logic       er,
    output logic       rt,
    output logic       interrupt,
    output logic       ack,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_DONE   = 3'd3,
        S_STOP   = 3'd4,
        S_ERR    = 3'd5,
        S_RETRY  = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic [1:0] retry_q, retry_d;
    logic [4:0] ack_q, ack_d;
    logic       accept_s;
    logic       wd_fire_s;

    assign accept_s  = (state_q == S_IDLE) && req;
    // Fires on the RUN cycle that completes timeout_cfg consecutive RUN cycles.
    assign wd_fire_s = (timeout_cfg != 8'd0) &&
                       (({1'b0, wd_q} + 9'd1) >= {1'b0, timeout_cfg});

    // Next-state, watchdog, retry counter and ack pipe computation.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        retry_d = retry_q;
        ack_d   = {ack_q[3:0], accept_s};
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_LAUNCH;
                    retry_d = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                wd_d = 8'd0;
                if (abort) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wd_d = (wd_q == 8'hFF) ? wd_q : (wd_q + 8'd1);
                if (abort) begin
                    state_d = S_STOP;
                end else if (eng_err) begin
                    state_d = S_ERR;
                end else if (eng_done) begin
                    state_d = S_DONE;
                end else if (wd_fire_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_STOP: state_d = S_IDLE;
            S_ERR: begin
                if (abort) begin
                    state_d = S_STOP;
                end else if (retry_q != 2'd3) begin
                    state_d = S_RETRY;
                    retry_d = retry_q + 2'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RETRY: begin
                if (abort) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers; reset discards the job and any pending ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wd_q    <= 8'd0;
            retry_q <= 2'd0;
            ack_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            retry_q <= retry_d;
            ack_q   <= ack_d;
        end
    end

    assign rdy       = (state_q == S_IDLE);
    assign start     = (state_q == S_LAUNCH);
    assign enable    = (state_q == S_RUN);
    assign endd      = (state_q == S_DONE);
    assign stop      = (state_q == S_STOP);
    assign er        = (state_q == S_ERR);
    assign rt        = (state_q == S_RETRY);
    // The final failed attempt reports completion from ERR itself.
    assign interrupt = (state_q == S_DONE) || (state_q == S_STOP) ||
                       ((state_q == S_ERR) && (retry_q == 2'd3));
    assign ack       = ack_q[4];
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_job_sequencer.sv
// Directed self-checking bench for job_sequencer; outputs sampled on falling edge.
module tb_job_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       abort = 1'b0;
    logic       eng_done = 1'b0;
    logic       eng_err = 1'b0;
    logic [7:0] timeout_cfg = 8'd0;
    logic       rdy, start, enable, endd, stop, er, rt, interrupt, ack;
    logic [1:0] retry_cnt;
    logic [8:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [8:0] O_RDY   = 9'h100;
    localparam logic [8:0] O_START = 9'h080;
    localparam logic [8:0] O_EN    = 9'h040;
    localparam logic [8:0] O_ENDD  = 9'h020;
    localparam logic [8:0] O_STOP  = 9'h010;
    localparam logic [8:0] O_ER    = 9'h008;
    localparam logic [8:0] O_RT    = 9'h004;
    localparam logic [8:0] O_INT   = 9'h002;
    localparam logic [8:0] O_ACK   = 9'h001;

    job_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .abort       (abort),
        .eng_done    (eng_done),
        .eng_err     (eng_err),
        .timeout_cfg (timeout_cfg),
        .rdy         (rdy),
        .start       (start),
        .enable      (enable),
        .endd        (endd),
        .stop        (stop),
        .er          (er),
        .rt          (rt),
        .interrupt   (interrupt),
        .ack         (ack),
        .retry_cnt   (retry_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {rdy, start, enable, endd, stop, er, rt, interrupt, ack};

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and check outputs and retry count.
    task automatic tick(input string tag, input logic [8:0] e_out, input logic [1:0] e_rc);
        @(negedge clk);
        check({tag, "/out"}, outs, e_out);
        check({tag, "/rc"}, {7'd0, retry_cnt}, {7'd0, e_rc});
    endtask

    initial begin
        // Reset state, then first acceptance on the first edge out of reset.
        @(negedge clk);
        check("reset/out", outs, O_RDY);
        check("reset/rc", {7'd0, retry_cnt}, 9'd0);
        rst = 1'b1;
        req = 1'b1;

        // Normal job; req held during the run must be ignored.
        tick("nrm_t1", O_START, 2'd0); req = 1'b0;
        tick("nrm_t2", O_EN, 2'd0);
        tick("nrm_t3", O_EN, 2'd0); req = 1'b1;
        tick("nrm_t4", O_EN, 2'd0);
        tick("nrm_t5", O_EN | O_ACK, 2'd0);
        tick("nrm_t6", O_EN, 2'd0);
        tick("nrm_t7", O_EN, 2'd0); eng_done = 1'b1;
        tick("nrm_t8", O_ENDD | O_INT, 2'd0); eng_done = 1'b0; req = 1'b0;
        tick("nrm_t9", O_RDY, 2'd0);

        // Watchdog of 4 RUN cycles, one retry, then abort in RUN.
        timeout_cfg = 8'd4; req = 1'b1;
        tick("wd_t1", O_START, 2'd0); req = 1'b0;
        tick("wd_t2", O_EN, 2'd0);
        tick("wd_t3", O_EN, 2'd0);
        tick("wd_t4", O_EN, 2'd0);
        tick("wd_t5", O_EN | O_ACK, 2'd0);
        tick("wd_t6", O_ER, 2'd0);
        tick("wd_t7", O_RT, 2'd1);
        tick("wd_t8", O_START, 2'd1);
        tick("wd_t9", O_EN, 2'd1); abort = 1'b1;
        tick("wd_t10", O_STOP | O_INT, 2'd1); abort = 1'b0;
        tick("wd_t11", O_RDY, 2'd1);

        // Retry exhaustion with eng_err held.
        timeout_cfg = 8'd0; eng_err = 1'b1; req = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick("ex_start", O_START | ((r == 1) ? O_ACK : 9'h000), 2'(r)); req = 1'b0;
            tick("ex_run", O_EN, 2'(r));
            tick("ex_er", O_ER, 2'(r));
            tick("ex_rt", O_RT, 2'(r + 1));
        end
        tick("ex_start4", O_START, 2'd3);
        tick("ex_run4", O_EN, 2'd3);
        tick("ex_final", O_ER | O_INT, 2'd3); eng_err = 1'b0;
        tick("ex_idle", O_RDY, 2'd3);
        tick("ex_hold", O_RDY, 2'd3);

        // Simultaneous abort/err/done in RUN; ack still emerges after abort.
        req = 1'b1;
        tick("sim_t1", O_START, 2'd0); req = 1'b0;
        tick("sim_t2", O_EN, 2'd0); abort = 1'b1; eng_err = 1'b1; eng_done = 1'b1;
        tick("sim_t3", O_STOP | O_INT, 2'd0); abort = 1'b0; eng_err = 1'b0; eng_done = 1'b0;
        tick("sim_t4", O_RDY, 2'd0);
        tick("sim_t5", O_RDY | O_ACK, 2'd0);

        // Overlapping acceptances: second job accepted before first ack.
        req = 1'b1;
        tick("ovl_t1", O_START, 2'd0); req = 1'b0;
        tick("ovl_t2", O_EN, 2'd0); eng_done = 1'b1;
        tick("ovl_t3", O_ENDD | O_INT, 2'd0); eng_done = 1'b0;
        tick("ovl_t4", O_RDY, 2'd0); req = 1'b1;
        tick("ovl_t5", O_START | O_ACK, 2'd0); req = 1'b0;
        tick("ovl_t6", O_EN, 2'd0); eng_done = 1'b1;
        tick("ovl_t7", O_ENDD | O_INT, 2'd0); eng_done = 1'b0;
        tick("ovl_t8", O_RDY, 2'd0);
        tick("ovl_t9", O_RDY | O_ACK, 2'd0);

        // Reset mid-RUN: immediate idle outputs and no pending ack.
        req = 1'b1;
        tick("rst_t1", O_START, 2'd0); req = 1'b0;
        tick("rst_t2", O_EN, 2'd0);
        tick("rst_t3", O_EN, 2'd0);
        rst = 1'b0;
        #1;
        check("rst_async/out", outs, O_RDY);
        check("rst_async/rc", {7'd0, retry_cnt}, 9'd0);
        tick("rst_t4", O_RDY, 2'd0); rst = 1'b1;
        tick("rst_t5", O_RDY, 2'd0);
        tick("rst_t6", O_RDY, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
